fft2video_uhd_4ppc: RTL and testbench

- Converts the 1-sample-per-clock complex FFT result stream (real/imag, tvalid, tlast, no backpressure) into a 4-pixel-per-clock AXI4-Stream gray video stream (tuser = SOF, tlast = EOL, tready).
- This is the transmit-side counterpart of the video-to-FFT path. It sits after the FFT core and feeds the gray-to-RGB visualiser and HDMI output.
- Each pixel is a saturated magnitude approximation, |re|+|im| >> SHIFT.

---
 rtl/fft2video_uhd_4ppc_if.sv | 27 ++
 rtl/fft2video_uhd_4ppc.sv | 231 +++++++++++++++++++++++
 tb/tb_fft2video_uhd_4ppc.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft2video_uhd_4ppc_if.sv
// fft2video_uhd_4ppc_if: complex FFT sample stream in, multi-pixel gray video stream out.
// The slave modport is the converter side; the master modport is the source/sink side.
interface fft2video_uhd_4ppc_if #(
    parameter int unsigned NPPC       = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FFT_WIDTH  = 32
);
    logic [FFT_WIDTH-1:0]       IN_treal;
    logic [FFT_WIDTH-1:0]       IN_timag;
    logic                       IN_tlast;
    logic                       IN_tvalid;
    logic [NPPC*DATA_WIDTH-1:0] VIDEO_OUT_tdata;
    logic                       VIDEO_OUT_tvalid;
    logic                       VIDEO_OUT_tready;
    logic                       VIDEO_OUT_tuser;
    logic                       VIDEO_OUT_tlast;

    modport master (
        output IN_treal, IN_timag, IN_tlast, IN_tvalid, VIDEO_OUT_tready,
        input  VIDEO_OUT_tdata, VIDEO_OUT_tvalid, VIDEO_OUT_tuser, VIDEO_OUT_tlast
    );

    modport slave (
        input  IN_treal, IN_timag, IN_tlast, IN_tvalid, VIDEO_OUT_tready,
        output VIDEO_OUT_tdata, VIDEO_OUT_tvalid, VIDEO_OUT_tuser, VIDEO_OUT_tlast
    );
endinterface

// File: rtl/fft2video_uhd_4ppc.sv
// fft2video_uhd_4ppc: turns a 1-sample/clock complex FFT stream into a 4-pixel/clock gray
// AXI4-Stream video stream. Pixel = saturate((|re| + |im|) >> SHIFT).
// Optional: define FFT2VIDEO_FRAME_CNT_EN to add the frame_count output.
module fft2video_uhd_4ppc #(
    parameter int unsigned NPPC       = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FFT_WIDTH  = 32,
    parameter int unsigned FFT_LENGTH = 64,
    parameter int unsigned HEIGHT     = 720,
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 s_axis_video_aclk,
    input  logic                 s_axis_video_aresetn,
    fft2video_uhd_4ppc_if.slave  bus,
    output logic                 overflow,
    output logic                 len_err
`ifdef FFT2VIDEO_FRAME_CNT_EN
    ,
    output logic [15:0]          frame_count
`endif
);
    localparam int unsigned WordW = NPPC * DATA_WIDTH;
    localparam int unsigned AbsW  = FFT_WIDTH - 1;
    localparam int unsigned SumW  = FFT_WIDTH + 1;
    localparam int unsigned LaneW = (NPPC > 1) ? $clog2(NPPC) : 1;
    localparam int unsigned SampW = (FFT_LENGTH > 1) ? $clog2(FFT_LENGTH) : 1;
    localparam int unsigned LineW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned AddrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW  = AddrW + 1;
    localparam int unsigned EntW  = WordW + 2;

    localparam logic [LaneW-1:0] LaneLast = LaneW'(NPPC - 1);
    localparam logic [SampW-1:0] SampLast = SampW'(FFT_LENGTH - 1);
    localparam logic [LineW-1:0] LineLast = LineW'(HEIGHT - 1);
    localparam logic [CntW-1:0]  MemFull  = CntW'(FIFO_DEPTH - 1);
    localparam logic [SumW-1:0]  PixMax   = SumW'((2 ** DATA_WIDTH) - 1);

    // Magnitude of a two's complement value; the most negative value clips to the max positive.
    function automatic logic [AbsW-1:0] sat_abs(input logic [FFT_WIDTH-1:0] x);
        logic [FFT_WIDTH-1:0] neg;
        neg = -x;
        if (!x[FFT_WIDTH-1]) begin
            return x[AbsW-1:0];
        end else if (x[AbsW-1:0] == '0) begin
            return '1;
        end else begin
            return neg[AbsW-1:0];
        end
    endfunction

    logic                  v1_q, last1_q;
    logic [AbsW-1:0]       abs_re_q, abs_im_q;
    logic                  v2_q, last2_q;
    logic [DATA_WIDTH-1:0] pix2_q;
    logic [SumW-1:0]       sum, shifted;
    logic [DATA_WIDTH-1:0] pix;

    logic [LaneW-1:0]      lane_q;
    logic [SampW-1:0]      sample_q;
    logic [LineW-1:0]      line_q;
    logic [WordW-1:0]      buf_q, cur_word;
    logic                  line_end, word_done, first_word;
    logic [WordW-1:0]      word_q;
    logic                  word_vld_q, word_last_q, word_sof_q;

    logic [EntW-1:0]       mem [FIFO_DEPTH];
    logic [AddrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       mem_cnt_q;
    logic                  out_valid_q, out_user_q, out_last_q;
    logic [WordW-1:0]      out_data_q;
    logic                  pop, full, push_ok, load, mem_rd, mem_wr, bypass, drop;
    logic [EntW-1:0]       push_ent;

    // Stage 1: register component magnitudes.
    always_ff @(posedge s_axis_video_aclk) begin
        if (!s_axis_video_aresetn) begin
            v1_q     <= 1'b0;
            last1_q  <= 1'b0;
            abs_re_q <= '0;
            abs_im_q <= '0;
        end else begin
            v1_q <= bus.IN_tvalid;
            if (bus.IN_tvalid) begin
                abs_re_q <= sat_abs(bus.IN_treal);
                abs_im_q <= sat_abs(bus.IN_timag);
                last1_q  <= bus.IN_tlast;
            end
        end
    end

    // Stage 2 datapath: sum, shift, saturate to pixel range.
    always_comb begin
        sum     = {2'b00, abs_re_q} + {2'b00, abs_im_q};
        shifted = sum >> SHIFT;
        pix     = (shifted > PixMax) ? '1 : shifted[DATA_WIDTH-1:0];
    end

    // Stage 2: register the pixel.
    always_ff @(posedge s_axis_video_aclk) begin
        if (!s_axis_video_aresetn) begin
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
            pix2_q  <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                pix2_q  <= pix;
                last2_q <= last1_q;
            end
        end
    end

    // Pack decode: insert the pixel into its lane and decide word/line completion.
    always_comb begin
        cur_word = buf_q;
        cur_word[lane_q*DATA_WIDTH +: DATA_WIDTH] = pix2_q;
        line_end   = last2_q || (sample_q == SampLast);
        word_done  = line_end || (lane_q == LaneLast);
        // Sample index equals lane index only within the first word of a line.
        first_word = (sample_q == SampW'(lane_q));
    end

    // Pack: lane/sample/line counters and the completed-word register.
    always_ff @(posedge s_axis_video_aclk) begin
        if (!s_axis_video_aresetn) begin
            lane_q      <= '0;
            sample_q    <= '0;
            line_q      <= '0;
            buf_q       <= '0;
            word_q      <= '0;
            word_vld_q  <= 1'b0;
            word_last_q <= 1'b0;
            word_sof_q  <= 1'b0;
            len_err     <= 1'b0;
        end else begin
            word_vld_q <= v2_q && word_done;
            if (v2_q) begin
                if (word_done) begin
                    word_q      <= cur_word;
                    word_last_q <= line_end;
                    word_sof_q  <= (line_q == '0) && first_word;
                    buf_q       <= '0;
                    lane_q      <= '0;
                end else begin
                    buf_q  <= cur_word;
                    lane_q <= lane_q + 1'b1;
                end
                if (line_end) begin
                    sample_q <= '0;
                    line_q   <= (line_q == LineLast) ? '0 : line_q + 1'b1;
                    if (last2_q != (sample_q == SampLast)) begin
                        len_err <= 1'b1;
                    end
                end else begin
                    sample_q <= sample_q + 1'b1;
                end
            end
        end
    end

    // FIFO control: the output register is the head, so total capacity is FIFO_DEPTH words.
    always_comb begin
        pop      = out_valid_q && bus.VIDEO_OUT_tready;
        full     = out_valid_q && (mem_cnt_q == MemFull);
        push_ok  = word_vld_q && (!full || pop);
        load     = !out_valid_q || pop;
        mem_rd   = load && (mem_cnt_q != '0);
        bypass   = load && (mem_cnt_q == '0) && push_ok;
        mem_wr   = push_ok && !bypass;
        drop     = word_vld_q && !push_ok;
        push_ent = {word_sof_q, word_last_q, word_q};
    end

    // FIFO storage; contents are don't-care while not counted.
    always_ff @(posedge s_axis_video_aclk) begin
        if (mem_wr) begin
            mem[wr_ptr_q] <= push_ent;
        end
    end

    // FIFO pointers, output register and overflow flag.
    always_ff @(posedge s_axis_video_aclk) begin
        if (!s_axis_video_aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_user_q  <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            overflow    <= 1'b0;
        end else begin
            if (mem_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (mem_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            mem_cnt_q <= mem_cnt_q + CntW'(mem_wr) - CntW'(mem_rd);
            if (mem_rd) begin
                out_valid_q                          <= 1'b1;
                {out_user_q, out_last_q, out_data_q} <= mem[rd_ptr_q];
            end else if (bypass) begin
                out_valid_q                          <= 1'b1;
                {out_user_q, out_last_q, out_data_q} <= push_ent;
            end else if (load) begin
                out_valid_q <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign bus.VIDEO_OUT_tvalid = out_valid_q;
    assign bus.VIDEO_OUT_tdata  = out_data_q;
    assign bus.VIDEO_OUT_tuser  = out_user_q;
    assign bus.VIDEO_OUT_tlast  = out_last_q;

`ifdef FFT2VIDEO_FRAME_CNT_EN
    // Count transferred start-of-frame beats.
    always_ff @(posedge s_axis_video_aclk) begin
        if (!s_axis_video_aresetn) begin
            frame_count <= '0;
        end else if (pop && out_user_q) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fft2video_uhd_4ppc.sv
// Directed self-checking bench for fft2video_uhd_4ppc (HEIGHT=4 so a frame wrap fits).
module tb_fft2video_uhd_4ppc;
    localparam int unsigned NPPC = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned FW   = 32;
    localparam int unsigned FL   = 64;
    localparam int unsigned H    = 4;

    logic clk = 1'b0;
    logic aresetn;
    logic overflow, len_err;
`ifdef FFT2VIDEO_FRAME_CNT_EN
    logic [15:0] frame_count;
`endif
    int cyc = 0;
    int n_total = 0;
    int n_bad = 0;
    logic [33:0] beats[$];
    int beat_cyc[$];

    fft2video_uhd_4ppc_if #(.NPPC(NPPC), .DATA_WIDTH(DW), .FFT_WIDTH(FW)) bus ();

    fft2video_uhd_4ppc #(
        .NPPC(NPPC), .DATA_WIDTH(DW), .FFT_WIDTH(FW), .FFT_LENGTH(FL),
        .HEIGHT(H), .SHIFT(8), .FIFO_DEPTH(16)
    ) dut (
        .s_axis_video_aclk(clk),
        .s_axis_video_aresetn(aresetn),
        .bus(bus),
        .overflow(overflow),
        .len_err(len_err)
`ifdef FFT2VIDEO_FRAME_CNT_EN
        ,
        .frame_count(frame_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every transferred beat, sampled mid-cycle.
    always @(negedge clk) begin
        if (aresetn && bus.VIDEO_OUT_tvalid && bus.VIDEO_OUT_tready) begin
            beats.push_back({bus.VIDEO_OUT_tuser, bus.VIDEO_OUT_tlast, bus.VIDEO_OUT_tdata});
            beat_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ramp_word(input int b);
        return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
    endfunction

    task automatic send(input logic [31:0] re, input logic [31:0] im, input logic last);
        bus.IN_treal  = re;
        bus.IN_timag  = im;
        bus.IN_tlast  = last;
        bus.IN_tvalid = 1'b1;
        @(posedge clk);
        #1;
        bus.IN_tvalid = 1'b0;
        bus.IN_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        aresetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic send_ramp_line(input int first_pix);
        for (int i = 0; i < 64; i++) begin
            send(32'((first_pix + i) * 256), 32'h0, i == 63);
        end
    endtask

    task automatic wait_beats(input string tag, input int base, input int n, input int budget);
        int k;
        k = 0;
        while ((beats.size() - base) < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        idle(4);
        check(tag, 64'(beats.size() - base), 64'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int s3_cyc;
        logic [33:0] b;

        aresetn              = 1'b0;
        bus.IN_treal         = '0;
        bus.IN_timag         = '0;
        bus.IN_tlast         = 1'b0;
        bus.IN_tvalid        = 1'b0;
        bus.VIDEO_OUT_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(bus.VIDEO_OUT_tvalid), 64'd0);
        check("rst_tdata", 64'(bus.VIDEO_OUT_tdata), 64'd0);
        check("rst_flags", {bus.VIDEO_OUT_tuser, bus.VIDEO_OUT_tlast, overflow, len_err}, 64'd0);
        aresetn = 1'b1;
        idle(1);

        // Ramp line with latency measurement.
        base   = beats.size();
        s3_cyc = 0;
        for (int i = 0; i < 64; i++) begin
            send(32'(i * 256), 32'h0, i == 63);
            if (i == 3) s3_cyc = cyc;
        end
        wait_beats("ramp_count", base, 16, 100);
        if (beats.size() - base >= 16) begin
            b = beats[base];
            check("ramp_b0_data", 64'(b[31:0]), 64'h03020100);
            check("ramp_b0_user", 64'(b[33]), 64'd1);
            check("ramp_b0_last", 64'(b[32]), 64'd0);
            check("ramp_latency", 64'(beat_cyc[base] - s3_cyc), 64'd3);
            b = beats[base + 15];
            check("ramp_b15_data", 64'(b[31:0]), 64'h3F3E3D3C);
            check("ramp_b15_last", 64'(b[32]), 64'd1);
        end
        check("ramp_len_err", 64'(len_err), 64'd0);
        check("ramp_overflow", 64'(overflow), 64'd0);
        check("ramp_idle", 64'(bus.VIDEO_OUT_tvalid), 64'd0);

        // Saturation and absolute value.
        reset_dut();
        base = beats.size();
        send(32'h80000000, 32'h0, 1'b0);
        send(32'hFFFFFE00, 32'hFFFFFF00, 1'b0);
        send(32'h0000FF00, 32'h00000100, 1'b0);
        send(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1);
        wait_beats("sat_count", base, 1, 20);
        if (beats.size() - base >= 1) begin
            check("sat_word", 64'(beats[base]), {2'b11, 32'hFFFF03FF});
        end
        check("sat_len_err", 64'(len_err), 64'd1);

        // Early tlast with input gaps.
        reset_dut();
        check("rst_len_err", 64'(len_err), 64'd0);
        base = beats.size();
        for (int i = 0; i < 6; i++) begin
            send(32'((i + 1) * 256), 32'h0, i == 5);
            idle(2);
        end
        wait_beats("early_count", base, 2, 30);
        if (beats.size() - base >= 2) begin
            check("early_b0", 64'(beats[base]), {2'b10, 32'h04030201});
            check("early_b1", 64'(beats[base + 1]), {2'b01, 32'h00000605});
        end
        check("early_len_err", 64'(len_err), 64'd1);

        // Backpressure and overflow.
        reset_dut();
        bus.VIDEO_OUT_tready = 1'b0;
        base = beats.size();
        for (int i = 0; i < 64; i++) begin
            send(32'(i * 256), 32'h0, i == 63);
        end
        idle(6);
        check("bp_ovf_before", 64'(overflow), 64'd0);
        check("bp_head", {bus.VIDEO_OUT_tvalid, bus.VIDEO_OUT_tuser, bus.VIDEO_OUT_tdata},
              {2'b11, 32'h03020100});
        for (int i = 64; i < 80; i++) begin
            send(32'(i * 256), 32'h0, 1'b0);
        end
        idle(6);
        check("bp_ovf_after", 64'(overflow), 64'd1);
        check("bp_head_held", {bus.VIDEO_OUT_tvalid, bus.VIDEO_OUT_tuser, bus.VIDEO_OUT_tdata},
              {2'b11, 32'h03020100});
        check("bp_no_xfer", 64'(beats.size() - base), 64'd0);
        bus.VIDEO_OUT_tready = 1'b1;
        wait_beats("bp_count", base, 16, 40);
        if (beats.size() - base >= 16) begin
            for (int k = 0; k < 16; k++) begin
                check($sformatf("bp_beat%0d", k), 64'(beats[base + k]),
                      {k == 0, k == 15, ramp_word(4 * k)});
            end
        end

        // Mid-line reset: flags set beforehand, then cleared.
        send(32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 11; i++) begin
            send(32'(i * 256), 32'h0, 1'b0);
        end
        check("mr_flags_set", {overflow, len_err}, 64'b11);
        aresetn = 1'b0;
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        check("mr_outputs", {bus.VIDEO_OUT_tvalid, bus.VIDEO_OUT_tuser, bus.VIDEO_OUT_tlast,
              bus.VIDEO_OUT_tdata, overflow, len_err}, 64'd0);
        idle(4);
        check("mr_empty", 64'(bus.VIDEO_OUT_tvalid), 64'd0);
        base = beats.size();
        send_ramp_line(0);
        wait_beats("mr_count", base, 16, 100);
        if (beats.size() - base >= 16) begin
            check("mr_b0", 64'(beats[base]), {2'b10, 32'h03020100});
        end
        check("mr_len_err", 64'(len_err), 64'd0);

        // Frame wrap over five lines with HEIGHT=4.
        reset_dut();
        base = beats.size();
        for (int l = 0; l < 5; l++) begin
            send_ramp_line(0);
        end
        wait_beats("fw_count", base, 80, 600);
        if (beats.size() - base >= 80) begin
            for (int k = 0; k < 80; k++) begin
                b = beats[base + k];
                check($sformatf("fw_beat%0d", k), 64'(b),
                      {(k == 0) || (k == 64), (k % 16) == 15, ramp_word(4 * (k % 16))});
            end
        end
`ifdef FFT2VIDEO_FRAME_CNT_EN
        check("fw_frame_count", 64'(frame_count), 64'd2);
`endif
        check("fw_flags", {overflow, len_err}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
